memoria_seq_banco: RTL and testbench



---
 rtl/memoria_seq_pkg.sv | 28 ++
 rtl/memoria_seq_banco_if.sv | 33 +++
 rtl/memoria_seq_fill.sv | 82 ++++++++
 rtl/memoria_seq_banco.sv | 97 +++++++++
 tb/tb_memoria_seq_banco.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/memoria_seq_pkg.sv
`default_nettype none
// ==== memoria_seq_pkg : state encoding, default sizes, preset pattern (rev 1.0) ====
package memoria_seq_pkg;

  localparam int DEF_DATA_WIDTH   = 4;
  localparam int DEF_ADDR_WIDTH   = 4;
  localparam int DEF_NUM_BANKS    = 4;
  localparam int PRESET_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_INIT_ALL = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RESTORE  = 2'd2
  } fill_state_e;

  function automatic int bank_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // One-hot word with bit (bank + addr) mod data_width set; callers keep the low data_width bits.
  function automatic logic [PRESET_MAX_WIDTH-1:0] preset_word(input int unsigned bank,
                                                              input int unsigned addr,
                                                              input int unsigned data_width);
    return PRESET_MAX_WIDTH'(1) << ((bank + addr) % data_width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/memoria_seq_banco_if.sv
`default_nettype none
// ==== memoria_seq_banco_if : request/response bundle of the sequence memory (rev 1.0) ====
interface memoria_seq_banco_if
  import memoria_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS
);
  localparam int BANK_WIDTH = bank_width(NUM_BANKS);

  logic                  rd_en;
  logic                  wr_en;
  logic                  restore;
  logic [BANK_WIDTH-1:0] bank;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  ready;

  modport master (
    output rd_en, wr_en, restore, bank, address, data_in,
    input  data_out, data_valid, ready
  );

  modport slave (
    input  rd_en, wr_en, restore, bank, address, data_in,
    output data_out, data_valid, ready
  );

endinterface
`default_nettype wire

// File: rtl/memoria_seq_fill.sv
`default_nettype none
// ==== memoria_seq_fill : preset fill sequencer (full init, single-bank restore) (rev 1.0) ====
module memoria_seq_fill
  import memoria_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int BANK_WIDTH = bank_width(NUM_BANKS)
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic                  restore_req,
  input  wire logic [BANK_WIDTH-1:0] restore_bank,
  output logic                       ready,
  output logic                       fill_we,
  output logic [BANK_WIDTH-1:0]      fill_bank,
  output logic [ADDR_WIDTH-1:0]      fill_addr,
  output logic [DATA_WIDTH-1:0]      fill_data
);
  localparam int IDX_WIDTH = BANK_WIDTH + ADDR_WIDTH;
  localparam int WORDS     = NUM_BANKS * (1 << ADDR_WIDTH);

  fill_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  // cnt is {bank, addr}: init walks every word, restore starts at {bank, 0} and stops at the bank's last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT_ALL: begin
        if (cnt_q == IDX_WIDTH'(WORDS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (restore_req) begin
          state_d = ST_RESTORE;
          cnt_d   = {restore_bank, {ADDR_WIDTH{1'b0}}};
        end
      end
      ST_RESTORE: begin
        if (&cnt_q[ADDR_WIDTH-1:0]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT_ALL;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT_ALL;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign fill_we   = (state_q != ST_IDLE);
  assign fill_bank = cnt_q[IDX_WIDTH-1 -: BANK_WIDTH];
  assign fill_addr = cnt_q[ADDR_WIDTH-1:0];
  assign fill_data = DATA_WIDTH'(preset_word(32'(fill_bank), 32'(fill_addr), DATA_WIDTH));

endmodule
`default_nettype wire

// File: rtl/memoria_seq_banco.sv
`default_nettype none
// ==== memoria_seq_banco : banked writable sequence memory with preset fill (rev 1.0) ====
module memoria_seq_banco
  import memoria_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
  input  wire logic          clock,
  input  wire logic          reset,
  memoria_seq_banco_if.slave bus
);
  localparam int BANK_WIDTH = bank_width(NUM_BANKS);
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int WORDS      = NUM_BANKS * DEPTH;
  localparam int IDX_WIDTH  = BANK_WIDTH + ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;

  logic                  ready;
  logic                  fill_we;
  logic [BANK_WIDTH-1:0] fill_bank;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;

  logic                  bank_ok;
  logic                  accept;
  logic                  rd_fire;
  logic                  user_we;
  logic                  restore_req;
  logic                  wr_we;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  memoria_seq_fill #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BANKS  (NUM_BANKS),
    .BANK_WIDTH (BANK_WIDTH)
  ) u_fill (
    .clock        (clock),
    .reset        (reset),
    .restore_req  (restore_req),
    .restore_bank (bus.bank),
    .ready        (ready),
    .fill_we      (fill_we),
    .fill_bank    (fill_bank),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data)
  );

  // A restore pulse pre-empts any read or write presented in the same cycle.
  always_comb begin
    bank_ok     = 32'(bus.bank) < NUM_BANKS;
    accept      = ready & ~bus.restore;
    rd_fire     = accept & bus.rd_en;
    user_we     = accept & bus.wr_en & bank_ok;
    restore_req = ready & bus.restore & bank_ok;
    rd_idx      = bank_ok ? {bus.bank, bus.address} : '0;

    wr_we   = fill_we | user_we;
    wr_idx  = fill_we ? {fill_bank, fill_addr} : {bus.bank, bus.address};
    wr_data = fill_we ? fill_data : bus.data_in;

    data_valid_d = rd_fire;
    data_out_d   = data_out_q;
    if (rd_fire) begin
      data_out_d = bank_ok ? mem_q[rd_idx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.ready      = ready;

endmodule
`default_nettype wire

// File: tb/tb_memoria_seq_banco.sv
`default_nettype none
// ==== tb_memoria_seq_banco : scoreboard bench, 4-bank and 3-bank instances (rev 1.0) ====
module tb_memoria_seq_banco;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  memoria_seq_banco_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(4)) bus0 ();
  memoria_seq_banco_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(3)) bus1 ();

  memoria_seq_banco #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(4)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0)
  );
  memoria_seq_banco #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(3)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1)
  );

  int              nb [2] = '{4, 3};
  logic [DW-1:0]   model [2][4][DEPTH];
  int              busy [2];
  logic [DW-1:0]   exp_q0 [$];
  logic [DW-1:0]   exp_q1 [$];
  int              vectors     = 0;
  int              miscompares = 0;

  function automatic logic [DW-1:0] ref_preset(int b, int a);
    logic [DW-1:0] one;
    one = 1;
    return one << ((a + b) % DW);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++)
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < DEPTH; a++)
          model[u][b][a] = ref_preset(b, a);
    busy[0] = 4 * DEPTH;
    busy[1] = 3 * DEPTH;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Behaviour at one rising edge: requests only count when the unit is not busy filling.
  task automatic model_edge(int u, bit rd, bit wr, bit rs, int b, int a, logic [DW-1:0] d);
    logic [DW-1:0] r;
    if (busy[u] > 0) begin
      busy[u]--;
      return;
    end
    if (rs) begin
      if (b < nb[u]) begin
        for (int i = 0; i < DEPTH; i++) model[u][b][i] = ref_preset(b, i);
        busy[u] = DEPTH;
      end
      return;
    end
    if (rd) begin
      r = (b < nb[u]) ? model[u][b][a] : '0;
      if (u == 0) exp_q0.push_back(r);
      else        exp_q1.push_back(r);
    end
    if (wr && b < nb[u]) model[u][b][a] = d;
  endtask

  task automatic idle_inputs();
    bus0.rd_en = 0; bus0.wr_en = 0; bus0.restore = 0; bus0.bank = 0; bus0.address = 0; bus0.data_in = 0;
    bus1.rd_en = 0; bus1.wr_en = 0; bus1.restore = 0; bus1.bank = 0; bus1.address = 0; bus1.data_in = 0;
  endtask

  task automatic step(int u, bit rd, bit wr, bit rs, int b, int a, int d);
    check("ready0", 32'(bus0.ready), 32'(busy[0] == 0));
    check("ready1", 32'(bus1.ready), 32'(busy[1] == 0));
    if (u == 0) begin
      bus0.rd_en = rd; bus0.wr_en = wr; bus0.restore = rs;
      bus0.bank = 2'(b); bus0.address = 4'(a); bus0.data_in = 4'(d);
    end else begin
      bus1.rd_en = rd; bus1.wr_en = wr; bus1.restore = rs;
      bus1.bank = 2'(b); bus1.address = 4'(a); bus1.data_in = 4'(d);
    end
    @(posedge clock);
    model_edge(0, (u == 0) && rd, (u == 0) && wr, (u == 0) && rs, b, a, 4'(d));
    model_edge(1, (u == 1) && rd, (u == 1) && wr, (u == 1) && rs, b, a, 4'(d));
    #1;
    idle_inputs();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_dout0"},  32'(bus0.data_out),   32'(0));
    check({tag, "_valid0"}, 32'(bus0.data_valid), 32'(0));
    check({tag, "_ready0"}, 32'(bus0.ready),      32'(0));
    check({tag, "_dout1"},  32'(bus1.data_out),   32'(0));
    check({tag, "_valid1"}, 32'(bus1.data_valid), 32'(0));
    check({tag, "_ready1"}, 32'(bus1.ready),      32'(0));
  endtask

  task automatic pulse_reset(string tag);
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: each data_valid must match the oldest outstanding read, and no read may go unanswered.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus0.data_valid) begin
        if (exp_q0.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_valid0: data_out %0h, expected no response", bus0.data_out);
        end else check("read0", 32'(bus0.data_out), 32'(exp_q0.pop_front()));
      end else if (exp_q0.size() != 0) begin
        vectors++; miscompares++;
        $display("FAIL missing_valid0: data_valid 0, expected %0h", exp_q0.pop_front());
      end
      if (bus1.data_valid) begin
        if (exp_q1.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_valid1: data_out %0h, expected no response", bus1.data_out);
        end else check("read1", 32'(bus1.data_out), 32'(exp_q1.pop_front()));
      end else if (exp_q1.size() != 0) begin
        vectors++; miscompares++;
        $display("FAIL missing_valid1: data_valid 0, expected %0h", exp_q1.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Power-on fill, then preset reads.
    idle(64);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 5, 0);
    step(0, 1, 0, 0, 3, 15, 0);

    // Write, read back, neighbour bank untouched.
    step(0, 0, 1, 0, 2, 7, 9);
    step(0, 1, 0, 0, 2, 7, 0);
    step(0, 1, 0, 0, 1, 7, 0);

    // Read-first on simultaneous read/write.
    step(0, 1, 1, 0, 0, 3, 15);
    step(0, 1, 0, 0, 0, 3, 0);

    // Overwrite bank 1, restore it, hammer requests while busy.
    for (int a = 0; a < 3; a++) step(0, 0, 1, 0, 1, a, 4'hA);
    step(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 2, 7, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 2, 7, 0);

    // Restore wins over a same-cycle read and write.
    step(0, 1, 1, 1, 0, 3, 0);
    idle(16);
    step(0, 1, 0, 0, 0, 3, 0);

    // Randomised traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 24) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)));
    end
    idle(20);

    // Three-bank instance: bank 3 reads zero, ignores writes and restore.
    step(1, 1, 0, 0, 3, 4, 0);
    step(1, 0, 1, 0, 3, 4, 15);
    step(1, 0, 0, 1, 3, 0, 0);
    for (int b = 0; b < 4; b++) step(1, 1, 0, 0, b, 4, 0);

    // Reset in the middle of a read response.
    step(0, 1, 0, 0, 0, 1, 0);
    pulse_reset("midread");

    // Reset 20 cycles into the fill; the fill must restart from word 0.
    idle(20);
    pulse_reset("midinit");
    idle(64);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 2, 7, 0);
    idle(2);

    check("queue0_drained", 32'(exp_q0.size()), 32'(0));
    check("queue1_drained", 32'(exp_q1.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
